// File: rtl/bsg_link_rx_checker_pkg.sv
// Shared types and constants for the link receive checker.
package bsg_link_rx_checker_pkg;

    typedef enum logic [0:0] {
        SYNC  = 1'b0,
        CHECK = 1'b1
    } state_e;

    localparam int words_width_c = 32;

endpackage

// File: rtl/bsg_link_rx_checker_sat_ctr.sv
// Counter that increments on incr and holds at all-ones instead of wrapping.
module bsg_link_rx_checker_sat_ctr #(
    parameter int width_p = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               incr,
    output logic [width_p-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (incr && (count != {width_p{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/bsg_link_rx_checker.sv
// Receive-side checker for an incrementing word stream from the link downstream core.
// Optional lock-loss recovery is enabled by defining BSG_LINK_RX_CHECKER_LOCK_LOSS_EN.
module bsg_link_rx_checker
    import bsg_link_rx_checker_pkg::*;
#(
    parameter int width_p     = 64,
    parameter int err_width_p = 16,
    parameter int lock_loss_p = 4
) (
    input  logic                     core_clk_i,
    input  logic                     core_reset_i,
    input  logic [width_p-1:0]       data_i,
    input  logic                     v_i,
    output logic                     yumi_o,
    input  logic                     hold_i,
    output logic                     locked_o,
    output logic [words_width_c-1:0] words_o,
    output logic [err_width_p-1:0]   errors_o,
    output logic [width_p-1:0]       last_data_o
);

    if (width_p < 16 || width_p > 64) begin : g_bad_width
        $error("bsg_link_rx_checker: width_p must be in 16..64");
    end
    if (lock_loss_p < 1) begin : g_bad_lock_loss
        $error("bsg_link_rx_checker: lock_loss_p must be at least 1");
    end

    logic                     acc_r;
    logic [width_p-1:0]       data_r;
    logic [width_p-1:0]       exp_r;
    logic [width_p-1:0]       last_r;
    logic [words_width_c-1:0] words_r;
    state_e                   state_r;
    logic                     mismatch;

`ifdef BSG_LINK_RX_CHECKER_LOCK_LOSS_EN
    localparam int miss_w_lp = $clog2(lock_loss_p + 1);
    localparam logic [miss_w_lp-1:0] miss_limit_lp = miss_w_lp'(lock_loss_p);
    logic [miss_w_lp-1:0] miss_cnt_r;
`endif

    assign yumi_o = v_i & ~hold_i & ~core_reset_i;

    // Stage 1: capture the consumed word; reset drops anything in flight.
    always_ff @(posedge core_clk_i) begin
        if (core_reset_i) begin
            acc_r  <= 1'b0;
            data_r <= '0;
        end else begin
            acc_r <= yumi_o;
            if (yumi_o) begin
                data_r <= data_i;
            end
        end
    end

    assign mismatch = acc_r & (state_r == CHECK) & (data_r != exp_r);

    // Stage 2: compare against the expected word and always resync to data_r+1.
    always_ff @(posedge core_clk_i) begin
        if (core_reset_i) begin
            state_r <= SYNC;
            words_r <= '0;
            last_r  <= '0;
            exp_r   <= '0;
`ifdef BSG_LINK_RX_CHECKER_LOCK_LOSS_EN
            miss_cnt_r <= '0;
`endif
        end else if (acc_r) begin
            words_r <= words_r + 1'b1;
            last_r  <= data_r;
            exp_r   <= data_r + 1'b1;
            case (state_r)
                SYNC:  state_r <= CHECK;
                CHECK: begin
`ifdef BSG_LINK_RX_CHECKER_LOCK_LOSS_EN
                    if (!mismatch) begin
                        miss_cnt_r <= '0;
                    end else if (miss_cnt_r == miss_limit_lp - 1'b1) begin
                        miss_cnt_r <= '0;
                        state_r    <= SYNC;
                    end else begin
                        miss_cnt_r <= miss_cnt_r + 1'b1;
                    end
`endif
                end
                default: state_r <= SYNC;
            endcase
        end
    end

    bsg_link_rx_checker_sat_ctr #(
        .width_p(err_width_p)
    ) err_ctr (
        .clk   (core_clk_i),
        .reset (core_reset_i),
        .incr  (mismatch),
        .count (errors_o)
    );

    assign locked_o    = (state_r == CHECK);
    assign words_o     = words_r;
    assign last_data_o = last_r;

endmodule

// File: tb/tb_bsg_link_rx_checker.sv
// Self-checking bench: a 64-bit default instance plus a 16-bit instance with a 4-bit error counter.
module tb_bsg_link_rx_checker;

`ifdef BSG_LINK_RX_CHECKER_LOCK_LOSS_EN
    localparam bit ll_en = 1'b1;
`else
    localparam bit ll_en = 1'b0;
`endif
    localparam int ll_limit = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst0 = 1'b1, v0 = 1'b0, h0 = 1'b0;
    logic [63:0] d0 = '0;
    logic        y0, lk0;
    logic [31:0] w0;
    logic [15:0] e0;
    logic [63:0] l0;

    logic        rst1 = 1'b1, v1 = 1'b0, h1 = 1'b0;
    logic [15:0] d1 = '0;
    logic        y1, lk1;
    logic [31:0] w1;
    logic [3:0]  e1;
    logic [15:0] l1;

    bsg_link_rx_checker dut0 (
        .core_clk_i(clk), .core_reset_i(rst0), .data_i(d0), .v_i(v0), .yumi_o(y0),
        .hold_i(h0), .locked_o(lk0), .words_o(w0), .errors_o(e0), .last_data_o(l0)
    );

    bsg_link_rx_checker #(.width_p(16), .err_width_p(4), .lock_loss_p(ll_limit)) dut1 (
        .core_clk_i(clk), .core_reset_i(rst1), .data_i(d1), .v_i(v1), .yumi_o(y1),
        .hold_i(h1), .locked_o(lk1), .words_o(w1), .errors_o(e1), .last_data_o(l1)
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: one entry per instance, updated per accepted word.
    int unsigned m_words[2];
    int          m_errs[2];
    bit          m_lock[2];
    int          m_miss[2];
    logic [63:0] m_exp[2];
    logic [63:0] m_last[2];

    function automatic logic [63:0] mask_of(input int s);
        return (s == 0) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_0000_FFFF;
    endfunction

    function automatic void model_reset(input int s);
        m_words[s] = 0; m_errs[s] = 0; m_lock[s] = 1'b0;
        m_miss[s] = 0; m_exp[s] = '0; m_last[s] = '0;
    endfunction

    function automatic void model_accept(input int s, input logic [63:0] din);
        logic [63:0] d;
        int          err_max;
        d = din & mask_of(s);
        err_max = (s == 0) ? 65535 : 15;
        m_words[s] = m_words[s] + 1;
        if (!m_lock[s]) begin
            m_lock[s] = 1'b1;
            m_miss[s] = 0;
        end else if (d != m_exp[s]) begin
            if (m_errs[s] < err_max) m_errs[s] = m_errs[s] + 1;
            m_miss[s] = m_miss[s] + 1;
            if (ll_en && m_miss[s] == ll_limit) begin
                m_lock[s] = 1'b0;
                m_miss[s] = 0;
            end
        end else begin
            m_miss[s] = 0;
        end
        m_exp[s]  = (d + 64'd1) & mask_of(s);
        m_last[s] = d;
    endfunction

    task automatic drive(input int s, input logic [63:0] d, input logic v, input logic h);
        @(negedge clk);
        if (s == 0) begin
            d0 = d; v0 = v; h0 = h; v1 = 1'b0;
            if (v && !h && !rst0) model_accept(0, d);
        end else begin
            d1 = d[15:0]; v1 = v; h1 = h; v0 = 1'b0;
            if (v && !h && !rst1) model_accept(1, d);
        end
    endtask

    task automatic settle(input int s);
        drive(s, '0, 1'b0, 1'b0);
        drive(s, '0, 1'b0, 1'b0);
    endtask

    task automatic reset_dut(input int s);
        @(negedge clk);
        if (s == 0) begin rst0 = 1'b1; v0 = 1'b0; end
        else        begin rst1 = 1'b1; v1 = 1'b0; end
        @(negedge clk);
        if (s == 0) rst0 = 1'b0; else rst1 = 1'b0;
        model_reset(s);
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst0 = 1'b1; rst1 = 1'b1; v0 = 1'b1; v1 = 1'b1; h0 = 1'b0; h1 = 1'b0;
        d0 = 64'd55; d1 = 16'd55;
        repeat (2) @(negedge clk);
        #1;
        n_chk++; if (y0 !== 1'b0)  begin n_err++; $display("FAIL reset_yumi0 got %0b want 0", y0); end
        n_chk++; if (y1 !== 1'b0)  begin n_err++; $display("FAIL reset_yumi1 got %0b want 0", y1); end
        n_chk++; if (w0 !== 32'd0) begin n_err++; $display("FAIL reset_words0 got %0d want 0", w0); end
        n_chk++; if (e0 !== 16'd0) begin n_err++; $display("FAIL reset_errors0 got %0d want 0", e0); end
        n_chk++; if (l0 !== 64'd0) begin n_err++; $display("FAIL reset_last0 got %0h want 0", l0); end
        n_chk++; if (lk0 !== 1'b0) begin n_err++; $display("FAIL reset_locked0 got %0b want 0", lk0); end
        n_chk++; if (w1 !== 32'd0 || e1 !== 4'd0 || l1 !== 16'd0 || lk1 !== 1'b0) begin
            n_err++; $display("FAIL reset_dut1 got w=%0d e=%0d l=%0h lk=%0b want all 0", w1, e1, l1, lk1);
        end
        v0 = 1'b0; v1 = 1'b0; rst0 = 1'b0; rst1 = 1'b0;
        model_reset(0); model_reset(1);
    endtask

    task automatic test_basic();
        drive(0, 64'd0, 1'b1, 1'b0);
        drive(0, 64'd1, 1'b1, 1'b0);
        #1;
        n_chk++; if (lk0 !== 1'b0) begin n_err++; $display("FAIL basic_lock_early got %0b want 0", lk0); end
        drive(0, 64'd2, 1'b1, 1'b0);
        #1;
        n_chk++; if (lk0 !== 1'b1) begin n_err++; $display("FAIL basic_lock_2edges got %0b want 1", lk0); end
        for (int i = 3; i < 10; i++) drive(0, 64'(i), 1'b1, 1'b0);
        settle(0);
        #1;
        n_chk++; if (w0 !== 32'd10 || w0 !== m_words[0]) begin n_err++; $display("FAIL basic_words got %0d want 10", w0); end
        n_chk++; if (e0 !== 16'd0) begin n_err++; $display("FAIL basic_errors got %0d want 0", e0); end
        n_chk++; if (l0 !== 64'd9) begin n_err++; $display("FAIL basic_last got %0d want 9", l0); end
    endtask

    task automatic test_resync();
        reset_dut(0);
        drive(0, 64'd5, 1'b1, 1'b0);
        drive(0, 64'd6, 1'b1, 1'b0);
        drive(0, 64'd8, 1'b1, 1'b0);
        settle(0);
        #1;
        n_chk++; if (e0 !== 16'd1 || e0 !== 16'(m_errs[0])) begin n_err++; $display("FAIL resync_err_after8 got %0d want 1", e0); end
        drive(0, 64'd9, 1'b1, 1'b0);
        settle(0);
        #1;
        n_chk++; if (e0 !== 16'd1) begin n_err++; $display("FAIL resync_err_after9 got %0d want 1", e0); end
        n_chk++; if (w0 !== 32'd4) begin n_err++; $display("FAIL resync_words got %0d want 4", w0); end
        n_chk++; if (lk0 !== 1'b1) begin n_err++; $display("FAIL resync_locked got %0b want 1", lk0); end
    endtask

    task automatic test_wrap();
        drive(1, 64'hFFFE, 1'b1, 1'b0);
        drive(1, 64'hFFFF, 1'b1, 1'b0);
        drive(1, 64'h0000, 1'b1, 1'b0);
        settle(1);
        #1;
        n_chk++; if (e1 !== 4'd0)  begin n_err++; $display("FAIL wrap_errors got %0d want 0", e1); end
        n_chk++; if (l1 !== 16'd0 || w1 !== 32'd3) begin n_err++; $display("FAIL wrap_last_words got l=%0h w=%0d want l=0 w=3", l1, w1); end
        n_chk++; if (lk1 !== 1'b1) begin n_err++; $display("FAIL wrap_locked got %0b want 1", lk1); end
    endtask

    task automatic test_hold();
        int unsigned words_before;
        words_before = m_words[0];
        for (int i = 0; i < 3; i++) begin
            drive(0, 64'd10, 1'b1, 1'b1);
            #1;
            n_chk++; if (y0 !== 1'b0) begin n_err++; $display("FAIL hold_yumi cycle %0d got %0b want 0", i, y0); end
        end
        #1;
        n_chk++; if (w0 !== words_before) begin n_err++; $display("FAIL hold_words got %0d want %0d", w0, words_before); end
        drive(0, 64'd10, 1'b1, 1'b0);
        #1;
        n_chk++; if (y0 !== 1'b1) begin n_err++; $display("FAIL hold_release_yumi got %0b want 1", y0); end
        drive(0, 64'd11, 1'b1, 1'b0);
        drive(0, 64'd12, 1'b1, 1'b0);
        settle(0);
        #1;
        n_chk++; if (e0 !== 16'd1 || w0 !== words_before + 3) begin
            n_err++; $display("FAIL hold_continue got e=%0d w=%0d want e=1 w=%0d", e0, w0, words_before + 3);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] prev, w;
        logic        v, h;
        prev = m_last[0];
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            h = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) == 0) w = {$urandom, $urandom};
            else                           w = prev + 64'd1;
            drive(0, w, v, h);
            if (v && !h) prev = w;
            #1;
            n_chk++; if (y0 !== (v & ~h)) begin n_err++; $display("FAIL rand_yumi cycle %0d got %0b want %0b", i, y0, v & ~h); end
        end
        settle(0);
        #1;
        n_chk++; if (w0 !== m_words[0]) begin n_err++; $display("FAIL rand_words got %0d want %0d", w0, m_words[0]); end
        n_chk++; if (e0 !== 16'(m_errs[0])) begin n_err++; $display("FAIL rand_errors got %0d want %0d", e0, m_errs[0]); end
        n_chk++; if (l0 !== m_last[0]) begin n_err++; $display("FAIL rand_last got %0h want %0h", l0, m_last[0]); end
        n_chk++; if (lk0 !== m_lock[0]) begin n_err++; $display("FAIL rand_locked got %0b want %0b", lk0, m_lock[0]); end
    endtask

    task automatic test_lock_loss();
        logic [63:0] prev, w;
        reset_dut(0);
        drive(0, 64'd0, 1'b1, 1'b0);
        drive(0, 64'd1, 1'b1, 1'b0);
        prev = 64'd1;
        for (int i = 0; i < 4; i++) begin
            w = {$urandom, $urandom};
            if (w == prev + 64'd1) w = w + 64'd7;
            drive(0, w, 1'b1, 1'b0);
            prev = w;
        end
        settle(0);
        #1;
        n_chk++; if (e0 !== 16'd4) begin n_err++; $display("FAIL lockloss_errors got %0d want 4", e0); end
        n_chk++; if (lk0 !== m_lock[0] || lk0 !== !ll_en) begin
            n_err++; $display("FAIL lockloss_locked got %0b want %0b", lk0, m_lock[0]);
        end
        w = {$urandom, $urandom};
        if (w == prev + 64'd1) w = w + 64'd3;
        drive(0, w, 1'b1, 1'b0);
        settle(0);
        #1;
        n_chk++; if (e0 !== 16'(m_errs[0]) || lk0 !== 1'b1) begin
            n_err++; $display("FAIL lockloss_relock got e=%0d lk=%0b want e=%0d lk=1", e0, lk0, m_errs[0]);
        end
    endtask

    task automatic test_mid_reset();
        drive(0, 64'd7, 1'b1, 1'b0);
        @(negedge clk);
        rst0 = 1'b1; v0 = 1'b0;
        @(negedge clk);
        #1;
        n_chk++; if (w0 !== 32'd0 || l0 !== 64'd0) begin n_err++; $display("FAIL midreset_clear got w=%0d l=%0h want 0 0", w0, l0); end
        rst0 = 1'b0;
        model_reset(0);
        drive(0, 64'd100, 1'b1, 1'b0);
        settle(0);
        #1;
        n_chk++; if (e0 !== 16'd0 || lk0 !== 1'b1) begin n_err++; $display("FAIL midreset_first got e=%0d lk=%0b want 0 1", e0, lk0); end
        n_chk++; if (w0 !== 32'd1 || l0 !== 64'd100) begin n_err++; $display("FAIL midreset_words got w=%0d l=%0d want 1 100", w0, l0); end
    endtask

    task automatic test_saturate();
        reset_dut(1);
        for (int i = 0; i < 20; i++) drive(1, 64'(2 * i), 1'b1, 1'b0);
        settle(1);
        #1;
        n_chk++; if (e1 !== 4'hF || e1 !== 4'(m_errs[1])) begin n_err++; $display("FAIL saturate_errors got %0d want 15", e1); end
        n_chk++; if (w1 !== m_words[1] || l1 !== 16'(m_last[1])) begin
            n_err++; $display("FAIL saturate_words got w=%0d l=%0d want w=%0d l=%0d", w1, l1, m_words[1], m_last[1]);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_resync();
        test_wrap();
        test_hold();
        test_back_to_back();
        test_lock_loss();
        test_mid_reset();
        test_saturate();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
